div_sar_arbiter: RTL and testbench
==================================

Name: div_sar_arbiter

Overview:
- Round-robin scheduler that shares one SAR divider instance among NREQ requesters.
- Latches the granted requester's operands and issues a one-cycle start pulse to the divider.
- Waits for the divider's end-of-operation pulse, then returns the quotient with a one-cycle ack to the owner.
- Sits between the control/datapath clients and the divider core; it is the only block driving the divider's stp.

Parameters:
- NREQ, 4, number of requesters (2..8).
- N1, 16, dividend width (matches divider n1).
- N2, 5, divisor width (matches divider n2); quotient width QW = N1-N2.
- TMO, 64, watchdog limit in cycles for the WAIT state (must exceed divider latency QW+4).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester request level; held high until the matching ack.
- a_bus  input  NREQ*N1  dividends; requester i at bits [i*N1 +: N1].
- b_bus  input  NREQ*N2  divisors; requester i at bits [i*N2 +: N2].
- ack  output  NREQ  one-hot, one-cycle completion pulse.
- q  output  QW  quotient; valid in the ack cycle, held afterwards.
- err  output  1  valid with ack; 1 = timeout (or zero divisor with the option enabled).
- busy  output  1  high from grant until the ack cycle inclusive.
- div_stp  output  1  one-cycle start pulse to the divider.
- div_a  output  N1  latched dividend to the divider.
- div_b  output  N2  latched divisor to the divider.
- div_r  input  QW  divider result.
- div_eop  input  1  divider end-of-operation pulse; div_r valid in the same cycle.

Behaviour:
- Reset (rst=0, asynchronous), in effect immediately:
  - state=IDLE; ack=0, q=0, err=0, busy=0, div_stp=0, div_a=0, div_b=0.
  - Round-robin pointer = 0; watchdog = 0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If req!=0, grant the first set bit searching from ptr upward, wrapping.
  - Latch owner index, div_a, div_b; busy=1; go to ISSUE.
- ISSUE: div_stp=1 for exactly this cycle; clear watchdog; go to WAIT.
- WAIT, on div_eop=1:
  - q<=div_r, err<=0; go to DONE.
  - div_eop in the same cycle as the watchdog limit is treated as success.
- WAIT, otherwise:
  - Increment watchdog.
  - At count TMO-1: q<=all ones, err<=1; go to DONE.
- DONE:
  - ack[owner]=1 for one cycle; busy=1 in this cycle.
  - ptr<=owner+1, wrapping at NREQ; go to IDLE.
- Arbitration is evaluated only in IDLE, so minimum spacing between grants is 4 cycles.
- Latency from grant to ack = 3 + divider cycles.
- Operands are sampled once at grant; later changes on a_bus/b_bus have no effect on the operation in flight.
- Owner dropping req mid-operation is ignored: the operation completes and ack still pulses.
- Requesters not granted keep waiting; starvation-free, with worst-case wait of NREQ-1 operations.
- div_eop outside WAIT is ignored; no state change.
- q and err hold their last value until the next DONE.
- Reset mid-operation aborts with no ack. The divider must be reset by the same rst; its stale eop is discarded by the previous rule.

Optional Feature:
- Macro: DIV_ZERO_BYPASS_EN.
- Defined:
  - In IDLE, a granted request with divisor==0 skips ISSUE/WAIT and goes straight to DONE.
  - q=all ones, err=1; div_stp not pulsed. Latency grant->ack = 2 cycles.
- Undefined:
  - A zero divisor is issued to the divider like any other operand.
  - Result is whatever the divider returns, err=0 unless the watchdog fires.

Test Plan:
- Single request: req=0001, A=1000, B=7 -> one div_stp pulse, then ack=0001 with q=142, err=0; busy low afterwards.
- Fairness: req=1111 held, each requester dropping req after its ack -> grants in order 0,1,2,3; reasserting all -> order restarts at 0 with ptr wrapped.
- Timeout: divider model never asserts div_eop -> ack after TMO-1 cycles in WAIT, q=2047, err=1; next request is serviced normally.
- Operand stability: change a_bus of the owner during WAIT -> q matches the operands latched at grant.
- Reset mid-WAIT: assert rst low during WAIT, release it, then inject a stray div_eop -> no ack, FSM stays in IDLE, all outputs 0.
- Zero divisor (DIV_ZERO_BYPASS_EN defined): req=0100, B=0 -> no div_stp, ack=0100 two cycles after grant, q=2047, err=1.

Source files
------------

// File: rtl/div_sar_arbiter.sv
// div_sar_arbiter: round-robin sharing of one SAR divider among NREQ requesters.
// Optional build macro DIV_ZERO_BYPASS_EN: a zero divisor completes at once with err=1.
module div_sar_arbiter #(
    parameter int NREQ = 4,
    parameter int N1 = 16,
    parameter int N2 = 5,
    parameter int TMO = 64,
    localparam int QW = N1 - N2,
    localparam int PW = $clog2(NREQ),
    localparam int WW = $clog2(TMO)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*N1-1:0] a_bus,
    input  logic [NREQ*N2-1:0] b_bus,
    output logic [NREQ-1:0]    ack,
    output logic [QW-1:0]      q,
    output logic               err,
    output logic               busy,
    output logic               div_stp,
    output logic [N1-1:0]      div_a,
    output logic [N2-1:0]      div_b,
    input  logic [QW-1:0]      div_r,
    input  logic               div_eop
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t state_q, state_d;
    logic [PW-1:0] owner_q, owner_d, ptr_q, ptr_d, gnt, k;
    logic [WW-1:0] wd_q, wd_d;
    logic [QW-1:0] q_q, q_d;
    logic err_q, err_d, found;
    logic [N1-1:0] a_q, a_d;
    logic [N2-1:0] b_q, b_d;
    int j;
    // first pending request at or after the pointer, wrapping; lowest offset wins
    always_comb begin
        found = 1'b0;
        gnt = '0;
        j = 0;
        k = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = int'(ptr_q) + i;
            if (j >= NREQ) j = j - NREQ;
            k = PW'(j);
            if (req[k]) begin
                found = 1'b1;
                gnt = k;
            end
        end
    end
    // next-state logic; eop is honoured before the watchdog so a tie counts as success
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d = ptr_q;
        wd_d = wd_q;
        q_d = q_q;
        err_d = err_q;
        a_d = a_q;
        b_d = b_q;
        case (state_q)
            IDLE: if (found) begin
                owner_d = gnt;
                a_d = a_bus[gnt*N1 +: N1];
                b_d = b_bus[gnt*N2 +: N2];
                state_d = ISSUE;
`ifdef DIV_ZERO_BYPASS_EN
                if (b_d == '0) begin
                    q_d = '1;
                    err_d = 1'b1;
                    state_d = DONE;
                end
`endif
            end
            ISSUE: begin
                wd_d = '0;
                state_d = WAIT;
            end
            WAIT: if (div_eop) begin
                q_d = div_r;
                err_d = 1'b0;
                state_d = DONE;
            end else begin
                wd_d = wd_q + 1'b1;
                if (wd_d == WW'(TMO - 1)) begin
                    q_d = '1;
                    err_d = 1'b1;
                    state_d = DONE;
                end
            end
            default: begin
                ptr_d = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                state_d = IDLE;
            end
        endcase
    end
    // state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q <= '0;
            wd_q <= '0;
            q_q <= '0;
            err_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q <= ptr_d;
            wd_q <= wd_d;
            q_q <= q_d;
            err_q <= err_d;
            a_q <= a_d;
            b_q <= b_d;
        end
    end
    // ack pulses for the owner during DONE only
    always_comb begin
        ack = '0;
        if (state_q == DONE) ack[owner_q] = 1'b1;
    end
    assign busy = state_q != IDLE;
    assign div_stp = state_q == ISSUE;
    assign q = q_q;
    assign err = err_q;
    assign div_a = a_q;
    assign div_b = b_q;
endmodule

// File: tb/tb_div_sar_arbiter.sv
// tb_div_sar_arbiter: directed checks of the divider arbiter against a fixed-latency divider model.
module tb_div_sar_arbiter;
    localparam int LAT = 13;
    logic clk = 1'b0, rst = 1'b0;
    logic [3:0] req = '0;
    logic [63:0] a_bus = '0;
    logic [19:0] b_bus = '0;
    logic [3:0] ack;
    logic [10:0] q, div_r;
    logic err, busy, div_stp, div_eop;
    logic [15:0] div_a, m_a;
    logic [4:0] div_b, m_b, m_cnt;
    logic mute = 1'b0, stray = 1'b0;
    int n_vec = 0, n_bad = 0;
    int lat, nstp;
    logic [3:0] ak;
    logic [10:0] qq;
    logic ee;
    logic [10:0] exp_q [4] = '{11'd33, 11'd28, 11'd33, 11'd36};

    div_sar_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .a_bus(a_bus), .b_bus(b_bus),
        .ack(ack), .q(q), .err(err), .busy(busy), .div_stp(div_stp),
        .div_a(div_a), .div_b(div_b), .div_r(div_r), .div_eop(div_eop)
    );

    always #5 clk = ~clk;

    // divider model: fixed latency, shares the arbiter reset
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt <= '0;
            m_a <= '0;
            m_b <= '0;
        end else if (div_stp) begin
            m_cnt <= 5'(LAT);
            m_a <= div_a;
            m_b <= div_b;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1'b1;
        end
    end
    assign div_r = (m_b == 0) ? '1 : 11'(m_a / 16'(m_b));
    assign div_eop = (m_cnt == 1 && !mute) || stray;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_op(input bit tamper, output int l, output int ns, output logic [3:0] a, output logic [10:0] r, output logic e);
        int cyc = 0, stp_at = 0;
        bit done = 0;
        l = -1; ns = 0; a = '0; r = '0; e = 1'b0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (div_stp) begin
                ns++;
                stp_at = cyc;
            end
            if (tamper && ns == 1 && cyc == stp_at + 2) begin
                a_bus[48 +: 16] = 16'd50;
                b_bus[15 +: 5] = 5'd1;
                req = '0;
            end
            if (ack != 0) begin
                done = 1;
                a = ack; r = q; e = err; l = cyc - stp_at;
                check("busy_at_ack", 32'(busy), 1);
            end
        end
        if (!done) check("ack_wait", 0, 1);
    endtask

    initial begin
        #1;
        check("rst_ack", 32'(ack), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_stp", 32'(div_stp), 0);
        check("rst_q", 32'(q), 0);
        check("rst_err", 32'(err), 0);
        check("rst_div_a", 32'(div_a), 0);
        check("rst_div_b", 32'(div_b), 0);
        a_bus = {16'd400, 16'd300, 16'd200, 16'd100};
        b_bus = {5'd11, 5'd9, 5'd7, 5'd3};
        @(negedge clk);
        rst = 1'b1;
        for (int r = 0; r < 2; r++) begin
            req = 4'b1111;
            for (int i = 0; i < 4; i++) begin
                run_op(0, lat, nstp, ak, qq, ee);
                check($sformatf("rr%0d_ack%0d", r, i), 32'(ak), 32'(1 << i));
                check($sformatf("rr%0d_q%0d", r, i), 32'(qq), 32'(exp_q[i]));
                req[i] = 1'b0;
            end
        end
        a_bus[0 +: 16] = 16'd1000;
        b_bus[0 +: 5] = 5'd7;
        req = 4'b0001;
        run_op(0, lat, nstp, ak, qq, ee);
        req = '0;
        check("single_ack", 32'(ak), 1);
        check("single_q", 32'(qq), 142);
        check("single_err", 32'(ee), 0);
        check("single_stp", 32'(nstp), 1);
        check("single_lat", 32'(lat), 14);
        @(negedge clk);
        check("single_busy_after", 32'(busy), 0);
        check("single_q_held", 32'(q), 142);
        mute = 1'b1;
        a_bus[16 +: 16] = 16'd500;
        b_bus[5 +: 5] = 5'd5;
        req = 4'b0010;
        run_op(0, lat, nstp, ak, qq, ee);
        req = '0;
        mute = 1'b0;
        check("tmo_ack", 32'(ak), 2);
        check("tmo_q", 32'(qq), 2047);
        check("tmo_err", 32'(ee), 1);
        check("tmo_lat", 32'(lat), 64);
        repeat (LAT) @(negedge clk);
        a_bus[32 +: 16] = 16'd1234;
        b_bus[10 +: 5] = 5'd10;
        req = 4'b0100;
        run_op(0, lat, nstp, ak, qq, ee);
        req = '0;
        check("post_tmo_ack", 32'(ak), 4);
        check("post_tmo_q", 32'(qq), 123);
        check("post_tmo_err", 32'(ee), 0);
        a_bus[48 +: 16] = 16'd4000;
        b_bus[15 +: 5] = 5'd9;
        req = 4'b1000;
        run_op(1, lat, nstp, ak, qq, ee);
        check("stable_ack", 32'(ak), 8);
        check("stable_q", 32'(qq), 444);
        check("stable_stp", 32'(nstp), 1);
        a_bus[0 +: 16] = 16'd600;
        b_bus[0 +: 5] = 5'd6;
        req = 4'b0001;
        for (int c = 0; c < 20 && !div_stp; c++) @(negedge clk);
        check("rst_mid_stp", 32'(div_stp), 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_q", 32'(q), 0);
        check("rst_mid_div_a", 32'(div_a), 0);
        req = '0;
        @(negedge clk);
        rst = 1'b1;
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("stray_ack%0d", c), 32'(ack), 0);
            check($sformatf("stray_busy%0d", c), 32'(busy), 0);
        end
        check("stray_q", 32'(q), 0);
        check("stray_err", 32'(err), 0);
        a_bus[32 +: 16] = 16'd77;
        b_bus[10 +: 5] = 5'd0;
        req = 4'b0100;
        run_op(0, lat, nstp, ak, qq, ee);
        req = '0;
        check("zero_ack", 32'(ak), 4);
        check("zero_q", 32'(qq), 2047);
`ifdef DIV_ZERO_BYPASS_EN
        check("zero_stp", 32'(nstp), 0);
        check("zero_err", 32'(ee), 1);
`else
        check("zero_stp", 32'(nstp), 1);
        check("zero_err", 32'(ee), 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
